// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart/ block family.
// State enum, parity encodings and baud counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Counter width for a count of 0..clks-1, never below one bit.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate down-counter; tick marks the last clk of a bit period.
// Reloads itself on tick, or immediately on load.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count down, restarting the period at zero or on request.
    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (load || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W bits LSB first, parity, stops.
// Define UART_TX_BREAK_EN to add the brk input for line-break generation.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] in,
`ifdef UART_TX_BREAK_EN
    input  logic              brk,
`endif
    output logic              out,
    output logic              done,
    output logic              busy
);

    localparam int BW = (DATA_W <= 2) ? 1 : $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              stop_q, stop_d;
    logic              brk_q, brk_d;
    logic              out_q, out_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              live_q, live_d;
    logic              load;
    logic              tick;
    logic              brk_in;
    logic              accept;

`ifdef UART_TX_BREAK_EN
    assign brk_in = brk;
`else
    assign brk_in = 1'b0;
`endif

    // live_q keeps ready low until the first clk after reset.
    assign ready  = live_q && en && (state_q == IDLE) && !brk_in && !brk_q;
    assign accept = ready && start;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .load(load),
        .tick(tick)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        stop_d  = stop_q;
        brk_d   = brk_q;
        done_d  = 1'b0;
        load    = 1'b0;
        live_d  = 1'b1;
        if (!en) begin
            state_d = IDLE;
            brk_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (brk_in) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        load    = 1'b1;
                    end else if (accept) begin
                        shift_d = in;
                        par_d   = (PARITY == PAR_ODD) ? ~^in : ^in;
                        bit_d   = '0;
                        load    = 1'b1;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick) state_d = DATA;
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == LAST) begin
                            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                            stop_d  = 1'b0;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            shift_d = shift_q >> 1;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if ((STOP_BITS == 2) && !stop_q) begin
                            stop_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = !brk_q;
                            brk_d   = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        unique case (state_d)
            IDLE:    out_d = !brk_d;
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
            PAR:     out_d = par_d;
            default: out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || brk_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            brk_q   <= 1'b0;
            out_q   <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            brk_q   <= brk_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            live_q  <= live_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: two parameter sets sharing clk/rst.
// Break checks compile in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en0, start0, ready0, out0, done0, busy0;
    logic [7:0] in0;
    logic       en1, start1, ready1, out1, done1, busy1;
    logic [6:0] in1;
`ifdef UART_TX_BREAK_EN
    logic       brk0;
    logic       brk1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Expected line levels per bit period, element 0 first.
    logic [0:10] fa5 = 11'b01010010101;
    logic [0:10] f55 = 11'b01010101001;
    logic [0:10] f0f = 11'b01111000001;
    logic [0:10] f3c = 11'b00011110001;
    logic [0:10] f00 = 11'b00000000111;

    uart_tx_param #(
        .DATA_W(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4)
    ) u0 (
        .clk(clk), .rst(rst), .en(en0), .start(start0),
        .ready(ready0), .in(in0),
`ifdef UART_TX_BREAK_EN
        .brk(brk0),
`endif
        .out(out0), .done(done0), .busy(busy0)
    );

    uart_tx_param #(
        .DATA_W(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(1)
    ) u1 (
        .clk(clk), .rst(rst), .en(en1), .start(start1),
        .ready(ready1), .in(in1),
`ifdef UART_TX_BREAK_EN
        .brk(brk1),
`endif
        .out(out1), .done(done1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait (bounded) for ready on u0, then present one word.
    task automatic accept0(input logic [7:0] d, input bit hold);
        int k = 0;
        @(negedge clk);
        while (!ready0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {31'd0, ready0}, 32'd1);
        start0 = 1'b1;
        in0    = d;
        @(posedge clk);
        #1;
        if (!hold) start0 = 1'b0;
    endtask

    // Check 44 cycles of a u0 frame and the done cycle after it.
    task automatic frame0(input string tag, input logic [0:10] e);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            check({tag, "_out"}, {31'd0, out0}, {31'd0, e[i/4]});
            check({tag, "_busy"}, {31'd0, busy0}, 32'd1);
        end
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done0}, 32'd1);
        check({tag, "_busy_end"}, {31'd0, busy0}, 32'd0);
        check({tag, "_out_end"}, {31'd0, out0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        en0 = 1'b1; start0 = 1'b0; in0 = '0;
        en1 = 1'b1; start1 = 1'b0; in1 = '0;
`ifdef UART_TX_BREAK_EN
        brk0 = 1'b0;
        brk1 = 1'b0;
`endif
        #3;
        check("rst_out", {31'd0, out0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_out1", {31'd0, out1}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rel_ready_lo", {31'd0, ready0}, 32'd0);
        @(negedge clk);
        check("rel_ready_hi", {31'd0, ready0}, 32'd1);

        // Even parity frame.
        accept0(8'hA5, 1'b0);
        frame0("a5", fa5);
        @(negedge clk);
        check("a5_done_pulse", {31'd0, done0}, 32'd0);

        // 7-bit odd parity, two stop bits, one clk per bit.
        @(negedge clk);
        check("u1_ready", {31'd0, ready1}, 32'd1);
        start1 = 1'b1;
        in1 = 7'h00;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("u1_out", {31'd0, out1}, {31'd0, f00[i]});
            check("u1_busy", {31'd0, busy1}, 32'd1);
        end
        @(negedge clk);
        check("u1_done", {31'd0, done1}, 32'd1);
        check("u1_busy_end", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        check("u1_done_pulse", {31'd0, done1}, 32'd0);

        // Back-to-back with start held high.
        accept0(8'h55, 1'b1);
        in0 = 8'h0F;
        frame0("b2b55", f55);
        check("b2b_ready", {31'd0, ready0}, 32'd1);
        @(posedge clk);
        #1 start0 = 1'b0;
        frame0("b2b0f", f0f);

        // Abort during data bit 3.
        accept0(8'h00, 1'b0);
        repeat (18) @(negedge clk);
        check("abort_pre_out", {31'd0, out0}, 32'd0);
        en0 = 1'b0;
        @(negedge clk);
        check("abort_out", {31'd0, out0}, 32'd1);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_ready", {31'd0, ready0}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | done0 | ~out0;
        end
        check("abort_quiet", {31'd0, seen}, 32'd0);
        en0 = 1'b1;
        accept0(8'h3C, 1'b0);
        frame0("3c", f3c);

        // Asynchronous reset between edges mid-frame.
        accept0(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out", {31'd0, out0}, 32'd1);
        check("arst_busy", {31'd0, busy0}, 32'd0);
        check("arst_ready", {31'd0, ready0}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_rel_lo", {31'd0, ready0}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_rel_hi", {31'd0, ready0}, 32'd1);

`ifdef UART_TX_BREAK_EN
        // Break for 20 clk, then one stop period of mark.
        @(negedge clk);
        brk0 = 1'b1;
        #1;
        check("brk_ready", {31'd0, ready0}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("brk_out", {31'd0, out0}, 32'd0);
            check("brk_busy", {31'd0, busy0}, 32'd1);
            check("brk_rdy", {31'd0, ready0}, 32'd0);
        end
        brk0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mab_out", {31'd0, out0}, 32'd1);
            check("mab_ready", {31'd0, ready0}, 32'd0);
            check("mab_done", {31'd0, done0}, 32'd0);
        end
        @(negedge clk);
        check("brk_end_ready", {31'd0, ready0}, 32'd1);
        check("brk_end_done", {31'd0, done0}, 32'd0);
        check("brk_end_out", {31'd0, out0}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
